ps2_kbd: RTL and testbench



---
 rtl/ps2_kbd.sv | 146 ++++++++++++++
 tb/tb_ps2_kbd.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronizes the pins, deframes 11-bit frames and
// queues good scan codes in a small FIFO presented with status on dout.
module ps2_kbd #(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 20000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   input  logic        sel,
   input  logic        rd,
   output logic [31:0] dout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
   localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
   logic                   clk_prev;
   logic                   clk_s, dat_s, fall;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift_reg;
   logic                   parity_bit;
   logic [TW-1:0]          to_cnt;
   logic                   start_frame, shift_en, parity_en, frame_done, timeout_hit;
   logic                   push, pop_req, do_push, do_pop, ovf_evt, err_evt;
   logic [7:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [AW:0]            count;
   logic                   ovf_flag, err_flag, valid;

   // Pins idle high, so the stages preset to 1 and reset never fakes a falling edge.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
         clk_prev <= clk_s;
      end
   end

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];
   assign fall  = clk_prev & ~clk_s;

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every comb output gets a default first, otherwise unassigned paths infer latches.
   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      shift_en    = 1'b0;
      parity_en   = 1'b0;
      frame_done  = 1'b0;
      timeout_hit = 1'b0;
      if (state != S_IDLE && to_cnt == TO_LIMIT) begin
         timeout_hit = 1'b1;
         state_nxt   = S_IDLE;
      end else if (fall) begin
         case (state)
            S_IDLE: if (!dat_s) begin
               start_frame = 1'b1;
               state_nxt   = S_DATA;
            end
            S_DATA: begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = S_PARITY;
            end
            S_PARITY: begin
               parity_en = 1'b1;
               state_nxt = S_STOP;
            end
            S_STOP: begin
               frame_done = 1'b1;
               state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         to_cnt     <= '0;
      end else begin
         if (start_frame) bit_cnt <= '0;
         if (shift_en) begin
            shift_reg <= {dat_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end
         if (parity_en) parity_bit <= dat_s;
         if (state == S_IDLE || fall || timeout_hit) to_cnt <= '0;
         else                                        to_cnt <= to_cnt + 1'b1;
      end
   end

   // Odd parity over data plus parity bit, and the stop bit must be high.
   assign push    = frame_done & dat_s & (^{shift_reg, parity_bit});
   assign err_evt = (frame_done & ~push) | timeout_hit;
   assign pop_req = sel & rd;
   assign valid   = (count != '0);
   assign do_pop  = pop_req & valid;
   assign do_push = push & ((count != FULL) | do_pop);
   assign ovf_evt = push & ~do_push;

   // NOTE: the storage array has no reset; count gates every read, so stale contents are never visible.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= shift_reg;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ovf_flag <= 1'b0;
         err_flag <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
         ovf_flag <= ovf_evt | (ovf_flag & ~pop_req);
         err_flag <= err_evt | (err_flag & ~pop_req);
      end
   end

   assign dout = {21'd0, err_flag, ovf_flag, valid, valid ? mem[rd_ptr] : 8'h00};

endmodule

// File: tb/tb_ps2_kbd.sv
// Self-checking bench for ps2_kbd: directed vector table, multi-cycle corner
// sequences and random traffic compared against a queue-based reference model.
module tb_ps2_kbd;

   localparam int DEPTH   = 8;
   localparam int SYNC    = 2;
   localparam int TIMEOUT = 20000;
   localparam int HALF    = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic        sel = 1'b0;
   logic        rd = 1'b0;
   logic [31:0] dout;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] q[$];
   bit         m_ovf, m_err;

   ps2_kbd #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .sel(sel), .rd(rd), .dout(dout)
   );

   always #5 clock = ~clock;

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef enum {A_SEND, A_POP, A_RD, A_SEL} act_e;
   typedef struct {
      act_e        act;
      logic [7:0]  data;
      bit          par_ok;
      bit          stop_b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_dout();
      bit v;
      v = (q.size() != 0);
      return {21'd0, m_err, m_ovf, v, v ? q[0] : 8'h00};
   endfunction

   function automatic void model_pop();
      if (q.size() != 0) void'(q.pop_front());
      m_ovf = 0;
      m_err = 0;
   endfunction

   task automatic bus_pulse(input bit s, input bit r);
      sel = s;
      rd  = r;
      @(negedge clock);
      sel = 1'b0;
      rd  = 1'b0;
      if (s && r) model_pop();
   endtask

   // Sends the first nbits bits of a frame; a complete frame updates the model.
   task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_b,
                             input int nbits, input bit pop_at_stop);
      logic [10:0] bits;
      bits = {stop_b, par_ok ? ~^b : ^b, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = bits[i];
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         if (i == 10 && pop_at_stop) begin
            repeat (SYNC) @(negedge clock);
            bus_pulse(1'b1, 1'b1);
            repeat (HALF - SYNC - 1) @(negedge clock);
         end else begin
            repeat (HALF) @(negedge clock);
         end
         ps2_clk = 1'b1;
      end
      if (nbits == 11) begin
         ps2_dat = 1'b1;
         repeat (4) @(negedge clock);
         if (par_ok && stop_b) begin
            if (q.size() < DEPTH) q.push_back(b);
            else                  m_ovf = 1;
         end else begin
            m_err = 1;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      q.delete();
      m_ovf = 0;
      m_err = 0;
      check("reset_dout", dout, 32'h0);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{A_SEND, 8'h1C, 1, 1, 32'h11C};
      vecs[1]  = '{A_POP,  8'h00, 1, 1, 32'h000};
      vecs[2]  = '{A_SEND, 8'hF0, 1, 1, 32'h1F0};
      vecs[3]  = '{A_SEND, 8'h1C, 1, 1, 32'h1F0};
      vecs[4]  = '{A_RD,   8'h00, 1, 1, 32'h1F0};
      vecs[5]  = '{A_SEL,  8'h00, 1, 1, 32'h1F0};
      vecs[6]  = '{A_POP,  8'h00, 1, 1, 32'h11C};
      vecs[7]  = '{A_POP,  8'h00, 1, 1, 32'h000};
      vecs[8]  = '{A_POP,  8'h00, 1, 1, 32'h000};
      vecs[9]  = '{A_SEND, 8'h33, 0, 1, 32'h400};
      vecs[10] = '{A_SEND, 8'h44, 1, 0, 32'h400};
      vecs[11] = '{A_SEND, 8'h5A, 1, 1, 32'h55A};
      vecs[12] = '{A_POP,  8'h00, 1, 1, 32'h000};

      repeat (3) @(negedge clock);
      do_reset();
      @(negedge clock);
      check("idle_after_reset", dout, 32'h0);

      foreach (vecs[i]) begin
         case (vecs[i].act)
            A_SEND: send_frame(vecs[i].data, vecs[i].par_ok, vecs[i].stop_b, 11, 0);
            A_POP:  bus_pulse(1'b1, 1'b1);
            A_RD:   bus_pulse(1'b0, 1'b1);
            A_SEL:  bus_pulse(1'b1, 1'b0);
            default: ;
         endcase
         check($sformatf("vec%0d", i), dout, vecs[i].exp);
      end

      // Overflow: nine frames into an eight-entry FIFO, then drain.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1, 1, 11, 0);
      check("ovf_full", dout, 32'h301);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ovf_read%0d", i), dout, (i == 0) ? 32'h301 : 32'h100 | 32'(i + 1));
         bus_pulse(1'b1, 1'b1);
      end
      check("ovf_drained", dout, 32'h000);

      // Timeout: abandon a frame after four data bits.
      send_frame(8'hA5, 1, 1, 5, 0);
      repeat (TIMEOUT - 1000) @(negedge clock);
      check("timeout_not_yet", dout, 32'h000);
      repeat (1100) @(negedge clock);
      m_err = 1;
      check("timeout_err", dout, 32'h400);
      send_frame(8'h5A, 1, 1, 11, 0);
      check("after_timeout", dout, 32'h55A);
      bus_pulse(1'b1, 1'b1);
      check("after_timeout_pop", dout, 32'h000);

      // Pop in the exact cycle the stop-bit falling edge pushes.
      send_frame(8'h11, 1, 1, 11, 0);
      check("sim_one", dout, 32'h111);
      send_frame(8'h22, 1, 1, 11, 1);
      check("sim_head", dout, 32'h122);
      bus_pulse(1'b1, 1'b1);
      check("sim_count1", dout, 32'h000);

      // Reset in mid-frame; the tail of that frame must not be received.
      send_frame(8'h66, 1, 1, 11, 0);
      check("pre_reset", dout, 32'h166);
      send_frame(8'hFF, 1, 1, 4, 0);
      do_reset();
      for (int i = 0; i < 7; i++) begin
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b1;
      end
      repeat (4) @(negedge clock);
      check("reset_tail_dropped", dout, 32'h000);

      // Random traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         int r, c;
         logic [7:0] b;
         r = $urandom_range(0, 9);
         c = $urandom_range(0, 6);
         b = 8'($urandom);
         if (r < 6)       send_frame(b, c != 0, c != 1, 11, 0);
         else if (r == 9) send_frame(b, c != 0, c != 1, 11, 1);
         else             bus_pulse(1'b1, 1'b1);
         check($sformatf("rand%0d", n), dout, model_dout());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
